// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// Run/opcode/flag inputs flow to the controller; strobes and status flow back.
interface multicycle_controller_if #(
    parameter int unsigned OPW = 5
);
    logic           en;
    logic [OPW-1:0] opcode;
    logic           zero;

    logic           loadA;
    logic           loadB;
    logic           loadC;
    logic           loadIR;
    logic           loadPC;
    logic           incPC;
    logic [2:0]     alu_op;
    logic           we_DM;
    logic           re_DM;
    logic           selA;
    logic           selB;
    logic           halted;
    logic           illegal;
    logic [2:0]     state_o;

    modport master (
        input  en, opcode, zero,
        output loadA, loadB, loadC, loadIR, loadPC, incPC, alu_op,
        output we_DM, re_DM, selA, selB, halted, illegal, state_o
    );

    modport slave (
        output en, opcode, zero,
        input  loadA, loadB, loadC, loadIR, loadPC, incPC, alu_op,
        input  we_DM, re_DM, selA, selB, halted, illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 19-bit CPU with configurable
// memory latency, conditional branch, HALT, run-enable pause and sticky illegal flag.
module multicycle_controller #(
    parameter int unsigned OPW     = 5,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNTW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StHalt   = 3'd6
    } state_e;

    localparam logic [OPW-1:0] OpNop = OPW'(5'h00);
    localparam logic [OPW-1:0] OpAdd = OPW'(5'h01);
    localparam logic [OPW-1:0] OpSub = OPW'(5'h02);
    localparam logic [OPW-1:0] OpAnd = OPW'(5'h03);
    localparam logic [OPW-1:0] OpOr  = OPW'(5'h04);
    localparam logic [OPW-1:0] OpXor = OPW'(5'h05);
    localparam logic [OPW-1:0] OpLd  = OPW'(5'h06);
    localparam logic [OPW-1:0] OpSt  = OPW'(5'h07);
    localparam logic [OPW-1:0] OpJmp = OPW'(5'h08);
    localparam logic [OPW-1:0] OpBeq = OPW'(5'h09);
    localparam logic [OPW-1:0] OpHlt = OPW'(5'h1F);

    localparam logic [CNTW-1:0] CntLast = CNTW'(MEM_LAT - 1);

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic           illegal_q, illegal_d;

    logic       load_a, load_b, load_c, load_ir, load_pc, inc_pc;
    logic [2:0] alu_op;
    logic       we_dm, re_dm, sel_a, sel_b;

    function automatic logic op_defined(input logic [OPW-1:0] op);
        case (op)
            OpNop, OpAdd, OpSub, OpAnd, OpOr, OpXor,
            OpLd, OpSt, OpJmp, OpBeq, OpHlt: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Everything holds while en is low so a pause resumes at the same cycle position.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        if (bus.en) begin
            case (state_q)
                StIdle:   state_d = StFetch;
                StFetch:  state_d = StDecode;
                StDecode: begin
                    op_d = bus.opcode;
                    if (!op_defined(bus.opcode)) begin
                        illegal_d = 1'b1;
                    end
                    state_d = (bus.opcode == OpHlt) ? StHalt : StExec;
                end
                StExec: begin
                    if (op_q == OpLd || op_q == OpSt) begin
                        cnt_d   = '0;
                        state_d = StMem;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StMem: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StFetch;
                    end
                end
                StHalt:   state_d = StHalt;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_c  = 1'b0;
        load_ir = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        alu_op  = 3'd0;
        we_dm   = 1'b0;
        re_dm   = 1'b0;
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        if (bus.en) begin
            case (state_q)
                StFetch: begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                StDecode: begin
                    load_a = 1'b1;
                    load_b = 1'b1;
                end
                StExec: begin
                    case (op_q)
                        OpAdd: begin load_c = 1'b1; alu_op = 3'd0; end
                        OpSub: begin load_c = 1'b1; alu_op = 3'd1; end
                        OpAnd: begin load_c = 1'b1; alu_op = 3'd2; end
                        OpOr:  begin load_c = 1'b1; alu_op = 3'd3; end
                        OpXor: begin load_c = 1'b1; alu_op = 3'd4; end
                        OpJmp: load_pc = 1'b1;
                        OpBeq: load_pc = bus.zero;
                        default: ;
                    endcase
                end
                StMem: begin
                    sel_b = 1'b1;
                    // Only LD and ST ever reach MEM.
                    if (op_q == OpLd) begin
                        re_dm = 1'b1;
                        if (cnt_q == CntLast) begin
                            load_c = 1'b1;
                            sel_a  = 1'b1;
                        end
                    end else if (cnt_q == CntLast) begin
                        we_dm = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.loadA   = load_a;
    assign bus.loadB   = load_b;
    assign bus.loadC   = load_c;
    assign bus.loadIR  = load_ir;
    assign bus.loadPC  = load_pc;
    assign bus.incPC   = inc_pc;
    assign bus.alu_op  = alu_op;
    assign bus.we_DM   = we_dm;
    assign bus.re_DM   = re_dm;
    assign bus.selA    = sel_a;
    assign bus.selB    = sel_b;
    assign bus.halted  = (state_q == StHalt);
    assign bus.illegal = illegal_q;
    assign bus.state_o = state_q;

endmodule
